// File: rtl/hist_eq_engine_if.sv
// Pixel stream bundle for hist_eq_engine: input beat channel and remapped output channel.
// master: the memory/register-file side; slave: the engine.
interface hist_eq_engine_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned LANES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*PIX_W-1:0] in_pix;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*PIX_W-1:0] out_pix;

    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_pix
    );

    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_pix
    );
endinterface

// File: rtl/hist_eq_engine.sv
// Two-pass streaming histogram equaliser: clear, accumulate, CDF/LUT build, remap.
// Optional HEQ_PERF_EN adds perf_cycles, a saturating count of busy cycles per frame.
module hist_eq_engine #(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned LOG2_NPIX = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    hist_eq_engine_if.slave bus,
    output logic            busy,
    output logic            done
`ifdef HEQ_PERF_EN
    ,
    output logic [31:0]     perf_cycles
`endif
);
    localparam int unsigned CNT_W  = LOG2_NPIX + 1;
    localparam int unsigned BINS   = 2 ** PIX_W;
    localparam int unsigned NPIX   = 2 ** LOG2_NPIX;
    localparam int unsigned NBEATS = NPIX / LANES;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PROD_W = CNT_W + PIX_W;

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StCdf, StRemap, StDone} state_e;

    state_e                 state_q, state_d;
    logic [PIX_W-1:0]       bin_q, bin_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;     // pixels applied (ACCUM) / beats accepted (REMAP)
    logic [CNT_W-1:0]       ocnt_q, ocnt_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic                   lane_act_q, lane_act_d;
    logic [LANES*PIX_W-1:0] beat_q, beat_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANES*PIX_W-1:0] out_pix_q, out_pix_d;

    logic [CNT_W-1:0]       hist [BINS];
    logic [PIX_W-1:0]       lut  [BINS];

    logic                   hist_we;
    logic [PIX_W-1:0]       hist_wa;
    logic [CNT_W-1:0]       hist_wd;
    logic                   lut_we;
    logic [PIX_W-1:0]       lut_wd;
    logic [CNT_W-1:0]       acc_sum;
    logic [PROD_W-1:0]      prod;
    logic [PROD_W-1:0]      scaled;
    logic [PIX_W-1:0]       app_pix;
    logic                   apply;
    logic                   in_ready;
    logic [LANES*PIX_W-1:0] lut_rd;

    assign busy          = (state_q != StIdle);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pix   = out_pix_q;

    // Parallel LUT lookup of every lane of the incoming beat.
    always_comb begin
        lut_rd = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lut_rd[l*PIX_W +: PIX_W] = lut[bus.in_pix[l*PIX_W +: PIX_W]];
        end
    end

    // Next-state, memory write control and handshake outputs.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        ocnt_d      = ocnt_q;
        acc_d       = acc_q;
        lane_d      = lane_q;
        lane_act_d  = lane_act_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        hist_we     = 1'b0;
        hist_wa     = bin_q;
        hist_wd     = '0;
        lut_we      = 1'b0;
        in_ready    = 1'b0;
        done        = 1'b0;
        apply       = 1'b0;
        app_pix     = bus.in_pix[PIX_W-1:0];
        acc_sum     = acc_q + hist[bin_q];
        // Full-width product so the scale never truncates before the shift.
        prod        = PROD_W'(acc_sum) * PROD_W'(BINS - 1);
        scaled      = prod >> LOG2_NPIX;
        if (scaled > PROD_W'(BINS - 1)) begin
            lut_wd = PIX_W'(BINS - 1);
        end else begin
            lut_wd = scaled[PIX_W-1:0];
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    bin_d   = '0;
                end
            end
            StClear: begin
                hist_we = 1'b1;
                bin_d   = bin_q + 1'b1;
                if (bin_q == PIX_W'(BINS - 1)) begin
                    state_d    = StAccum;
                    cnt_d      = '0;
                    lane_act_d = 1'b0;
                end
            end
            StAccum: begin
                in_ready = ~lane_act_q;
                // Lane 0 is applied in the accept cycle, the rest from the latched beat.
                if (lane_act_q) begin
                    apply   = 1'b1;
                    app_pix = beat_q[lane_q*PIX_W +: PIX_W];
                    lane_d  = lane_q + 1'b1;
                    if (lane_q == LANE_W'(LANES - 1)) begin
                        lane_act_d = 1'b0;
                    end
                end else if (bus.in_valid) begin
                    apply  = 1'b1;
                    beat_d = bus.in_pix;
                    if (LANES > 1) begin
                        lane_act_d = 1'b1;
                        lane_d     = LANE_W'(1);
                    end
                end
                if (apply) begin
                    hist_we = 1'b1;
                    hist_wa = app_pix;
                    hist_wd = hist[app_pix] + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NPIX - 1)) begin
                        state_d    = StCdf;
                        bin_d      = '0;
                        acc_d      = '0;
                        lane_act_d = 1'b0;
                    end
                end
            end
            StCdf: begin
                lut_we = 1'b1;
                acc_d  = acc_sum;
                bin_d  = bin_q + 1'b1;
                if (bin_q == PIX_W'(BINS - 1)) begin
                    state_d     = StRemap;
                    cnt_d       = '0;
                    ocnt_d      = '0;
                    out_valid_d = 1'b0;
                end
            end
            StRemap: begin
                in_ready = (bus.out_ready | ~out_valid_q) & (cnt_q < CNT_W'(NBEATS));
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    ocnt_d      = ocnt_q + 1'b1;
                    if (ocnt_q == CNT_W'(NBEATS - 1)) begin
                        state_d = StDone;
                    end
                end
                if (in_ready && bus.in_valid) begin
                    out_valid_d = 1'b1;
                    out_pix_d   = lut_rd;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and datapath state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bin_q       <= '0;
            cnt_q       <= '0;
            ocnt_q      <= '0;
            acc_q       <= '0;
            lane_q      <= '0;
            lane_act_q  <= 1'b0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            ocnt_q      <= ocnt_d;
            acc_q       <= acc_d;
            lane_q      <= lane_d;
            lane_act_q  <= lane_act_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
        end
    end

    // Histogram memory; contents are don't-care until CLEAR runs.
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist[hist_wa] <= hist_wd;
        end
    end

    // Remap LUT memory, written one bin per cycle during the CDF scan.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut[bin_q] <= lut_wd;
        end
    end

`ifdef HEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    assign perf_cycles = perf_q;

    // Busy-cycle counter: cleared on start, frozen from DONE, saturating.
    always_comb begin
        perf_d = perf_q;
        if (state_q == StIdle && start) begin
            perf_d = '0;
        end else if (busy && state_q != StDone && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 1'b1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end
`endif
endmodule

// File: tb/tb_hist_eq_engine.sv
// Self-checking bench for hist_eq_engine. Two instances: a 16-pixel frame engine (sel=0)
// and a 256-pixel frame engine (sel=1). Define HEQ_PERF_EN to also check perf_cycles.
`timescale 1ns/1ps
module tb_hist_eq_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pix = '0;
    logic        out_ready;
    logic        ready_mode = 1'b0;

    always #5 clk = ~clk;

    hist_eq_engine_if #(.PIX_W(8), .LANES(4)) bus_a ();
    hist_eq_engine_if #(.PIX_W(8), .LANES(4)) bus_b ();

    logic start_a, start_b, busy_a, busy_b, done_a, done_b;
    assign start_a         = !sel && start;
    assign start_b         = sel && start;
    assign bus_a.in_valid  = !sel && in_valid;
    assign bus_b.in_valid  = sel && in_valid;
    assign bus_a.in_pix    = in_pix;
    assign bus_b.in_pix    = in_pix;
    assign bus_a.out_ready = out_ready;
    assign bus_b.out_ready = out_ready;

    logic        busy, done, in_ready, out_valid;
    logic [31:0] out_pix;
    assign busy      = sel ? busy_b : busy_a;
    assign done      = sel ? done_b : done_a;
    assign in_ready  = sel ? bus_b.in_ready : bus_a.in_ready;
    assign out_valid = sel ? bus_b.out_valid : bus_a.out_valid;
    assign out_pix   = sel ? bus_b.out_pix : bus_a.out_pix;

`ifdef HEQ_PERF_EN
    logic [31:0] perf_a, perf_b, perf;
    assign perf = sel ? perf_b : perf_a;
`endif

    hist_eq_engine #(.PIX_W(8), .LANES(4), .LOG2_NPIX(4)) u_dut_a (
        .clk   (clk),
        .reset (rst_n),
        .start (start_a),
        .bus   (bus_a),
        .busy  (busy_a),
        .done  (done_a)
`ifdef HEQ_PERF_EN
        ,
        .perf_cycles (perf_a)
`endif
    );

    hist_eq_engine #(.PIX_W(8), .LANES(4), .LOG2_NPIX(8)) u_dut_b (
        .clk   (clk),
        .reset (rst_n),
        .start (start_b),
        .bus   (bus_b),
        .busy  (busy_b),
        .done  (done_b)
`ifdef HEQ_PERF_EN
        ,
        .perf_cycles (perf_b)
`endif
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          hung = 1'b0;
    int          frame_px [256];
    int          model_hist [256];
    int          model_lut [256];
    logic [31:0] exp_beats [64];
    logic [31:0] got_beats [64];
    int          out_idx = 0;
    int          acc_all = 0;
    int          done_cnt = 0;
    int          start_cyc = 0;
    int          last_lat = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int nbeats();
        return sel ? 64 : 4;
    endfunction

    // Reference model: histogram, CDF and LUT straight from the equalisation formula.
    task automatic build_model();
        int nb = nbeats();
        int lg = sel ? 8 : 4;
        int acc = 0;
        int v;
        for (int b = 0; b < 256; b++) model_hist[b] = 0;
        for (int i = 0; i < nb * 4; i++) model_hist[frame_px[i]]++;
        for (int b = 0; b < 256; b++) begin
            acc += model_hist[b];
            v = (acc * 255) >> lg;
            model_lut[b] = (v > 255) ? 255 : v;
        end
        for (int k = 0; k < 64; k++) begin
            exp_beats[k] = '0;
            got_beats[k] = '0;
        end
        for (int k = 0; k < nb; k++) begin
            for (int l = 0; l < 4; l++) begin
                exp_beats[k][l*8 +: 8] = 8'(model_lut[frame_px[4*k+l]]);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream ready: always 1, or the repeating stall pattern 1,0,0,1.
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                out_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Compare process: output beats, stall stability, REMAP ready rule, done/latency.
    initial begin
        bit          stall_prev;
        logic [31:0] stall_pix;
        int          nb;
        stall_prev = 1'b0;
        stall_pix = '0;
        forever begin
            @(negedge clk);
            nb = nbeats();
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (start && !busy) begin
                    build_model();
                    out_idx = 0;
                    acc_all = 0;
                    done_cnt = 0;
                    start_cyc = cyc + 1;
                    stall_prev = 1'b0;
                end
                if (out_valid) begin
                    check("in_ready_rule", in_ready, out_ready && ((acc_all - nb) < nb));
                    if (stall_prev) check("stall_hold", out_pix, stall_pix);
                    if (out_ready) begin
                        if (out_idx < nb) begin
                            check("out_pix", out_pix, exp_beats[out_idx]);
                            got_beats[out_idx] = out_pix;
                        end else begin
                            check("extra_beat", out_idx, nb - 1);
                        end
                        out_idx++;
                    end
                    stall_prev = !out_ready;
                    stall_pix = out_pix;
                end else begin
                    if (stall_prev) check("stall_valid", out_valid, 1);
                    stall_prev = 1'b0;
                end
                if (done) begin
                    done_cnt++;
                    last_lat = cyc - start_cyc;
`ifdef HEQ_PERF_EN
                    check("perf_at_done", perf, last_lat);
`endif
                end
                if (in_valid && in_ready) acc_all++;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input int idx);
        int n = 0;
        if (hung) return;
        in_valid = 1'b1;
        in_pix = {8'(frame_px[4*idx+3]), 8'(frame_px[4*idx+2]),
                  8'(frame_px[4*idx+1]), 8'(frame_px[4*idx])};
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 3000);
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            hung = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full frame: start, accumulate pass, re-stream for remap, then wait for done.
    task automatic run_frame(input int mid_start);
        int nb = nbeats();
        int n = 0;
        @(posedge clk);
        #1;
        pulse_start();
        for (int k = 0; k < 2 * nb; k++) begin
            send_beat(k % nb);
            if (k == mid_start) pulse_start();
        end
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("beats_out", out_idx, nb);
`ifdef HEQ_PERF_EN
        check("perf_hold", perf, last_lat);
`endif
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", {busy_a, busy_b}, 0);
        check("rst_done", {done_a, done_b}, 0);
        check("rst_in_ready", {bus_a.in_ready, bus_b.in_ready}, 0);
        check("rst_out_valid", {bus_a.out_valid, bus_b.out_valid}, 0);
        check("rst_out_pix", {bus_a.out_pix, bus_b.out_pix}, 0);
`ifdef HEQ_PERF_EN
        check("rst_perf", {perf_a, perf_b}, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Uniform frame, no stalls: all 0x10 -> every lane 0xFF.
        for (int i = 0; i < 256; i++) frame_px[i] = 8'h10;
        run_frame(-1);
        check("uni_lut_0f", model_lut[8'h0F], 0);
        check("uni_lut_10", model_lut[8'h10], 8'hFF);
        for (int k = 0; k < 4; k++) check("uni_beat", got_beats[k], 32'hFFFF_FFFF);
        check("uni_latency", last_lat, 533);
`ifdef HEQ_PERF_EN
        check("uni_perf", perf, 533);
`endif

        // Intra-beat duplicates.
        for (int i = 0; i < 16; i++) frame_px[i] = (i < 4) ? 8'h05 : 8'hFF;
        run_frame(-1);
        check("dup_hist5", model_hist[5], 4);
        check("dup_hist255", model_hist[255], 12);
        check("dup_beat0", got_beats[0], 32'h3F3F_3F3F);
        check("dup_beat1", got_beats[1], 32'hFFFF_FFFF);

        // Backpressure on the output during REMAP.
        for (int i = 0; i < 16; i++) frame_px[i] = (i * 37 + 3) & 8'hFF;
        ready_mode = 1'b1;
        run_frame(-1);
        ready_mode = 1'b0;

        // Reset mid-ACCUM after two beats, then a clean uniform frame with a stray start.
        for (int i = 0; i < 16; i++) frame_px[i] = 8'h10;
        @(posedge clk);
        #1;
        pulse_start();
        send_beat(0);
        send_beat(1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(1);
        for (int k = 0; k < 4; k++) check("clean_beat", got_beats[k], 32'hFFFF_FFFF);

        // Ramp frame on the 256-pixel engine.
        sel = 1'b1;
        for (int i = 0; i < 256; i++) frame_px[i] = i;
        run_frame(-1);
        check("ramp_px0", got_beats[0][7:0], 8'h00);
        check("ramp_px127", got_beats[31][31:24], 8'h7F);
        check("ramp_px255", got_beats[63][31:24], 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hist_eq_engine.md
Name: hist_eq_engine

Overview:
Parametrised streaming histogram-equalisation engine. It generalises the current fixed 128-bit vector datapath, its dual histogram memories, accumulator and new-image store into one self-sequenced block. The block runs two passes over one image frame:
- Pass 1 accumulates a per-bin histogram.
- An internal scan then builds the CDF and the remap LUT.
- Pass 2 remaps the re-streamed frame through the LUT.

It sits between the image memories and the vector register file as a bus-attached accelerator.

Parameters:
PIX_W, 8, pixel width; BINS = 2**PIX_W.
LANES, 4, pixels per input/output beat; power of two.
LOG2_NPIX, 12, frame size is 2**LOG2_NPIX pixels; must be >= log2(LANES).
CNT_W, LOG2_NPIX+1, bin counter and CDF width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted at 0).
start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
in_valid  in  1  input beat valid.
in_ready  out  1  engine accepts input beat this cycle.
in_pix  in  LANES*PIX_W  input pixels; lane 0 in LSBs.
out_valid  out  1  remapped beat valid.
out_ready  in  1  downstream accepts output beat.
out_pix  out  LANES*PIX_W  remapped pixels, same lane order.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, including in_ready, out_valid and out_pix. Counters are 0. Histogram and LUT RAM contents are don't-care.
- States: IDLE, CLEAR, ACCUM, CDF, REMAP, DONE.
- IDLE:
  - start=1 -> CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - Zeroes hist[0..BINS-1], one bin per cycle.
  - Takes exactly BINS cycles, then -> ACCUM.
- ACCUM:
  - A beat is accepted when in_valid and in_ready are both high.
  - After acceptance, in_ready drops. The beat's lanes are applied serially, lane 0 first: hist[pix] += 1, one lane per cycle (LANES cycles).
  - in_ready reasserts the cycle after the last lane is applied.
  - Serial lane processing makes duplicate pixels inside one beat count correctly.
  - The first in_ready rise is the cycle after entering ACCUM.
  - After 2**LOG2_NPIX pixels are applied -> CDF. Extra beats are not accepted (in_ready stays 0).
  - Bin counters cannot overflow: CNT_W holds 2**LOG2_NPIX.
- CDF:
  - Runs for BINS cycles, b = 0..BINS-1, with running sum acc += hist[b].
  - lut[b] = min(BINS-1, (acc*(BINS-1)) >> LOG2_NPIX). The product is CNT_W+PIX_W bits wide, with no intermediate truncation.
  - Then -> REMAP.
- REMAP:
  - in_ready = out_ready | ~out_valid.
  - An accepted beat produces out_pix with all lanes looked up in parallel (LUT is LANES read ports or replicated). Latency is 1 cycle.
  - out_valid is held with data stable while out_ready=0.
  - Throughput is 1 beat/cycle with no bubbles under continuous valid/ready.
  - After 2**LOG2_NPIX/LANES beats have been transferred out (out_valid & out_ready) -> DONE.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE.
  - out_valid is 0 in DONE.
- in_valid while in_ready=0 is held by the source. The engine never drops or duplicates a beat.
- Reset mid-operation aborts immediately to IDLE. The next start performs a full CLEAR; no stale counts survive.
- Minimum frame latency, start to done: 1 + BINS + LANES*(NPIX/LANES) + NPIX/LANES + BINS + 2 cycles (each term ±1 at the state boundaries, which the bench measures and locks).

Optional Feature:
- HEQ_PERF_EN: adds output port perf_cycles [31:0].
  - Cleared on an accepted start.
  - Increments every cycle while busy=1.
  - Frozen at its final value from the DONE cycle until the next start.
  - Saturates at 32'hFFFF_FFFF.
  - Reset value is 0.
- Without the macro: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Uniform frame: LOG2_NPIX=4, LANES=4, 4 beats of all 0x10, replayed in REMAP -> every out_pix lane = 0xFF. Bins 0x00..0x0F map to 0x00. done pulses once.
- Ramp frame: LOG2_NPIX=8, pixels 0..255, each once -> lut[b] = ((b+1)*255)>>8, so pixel 0 -> 0x00, pixel 127 -> 0x7F, pixel 255 -> 0xFF.
- Intra-beat duplicates: beat {0x05,0x05,0x05,0x05} plus 3 beats of 0xFF -> hist[5]=4, hist[255]=12. Pixel 5 remaps to (4*255)>>4 = 0x3F.
- Backpressure: REMAP with out_ready toggled 1,0,0,1 -> out_pix is stable while stalled. Beat count equals input count. in_ready follows out_ready | ~out_valid.
- Reset mid-ACCUM after 2 beats, then a clean uniform frame -> results match the uniform test exactly. start pulsed during busy -> ignored, with no second done.
- HEQ_PERF_EN build: LOG2_NPIX=4 frame with no stalls -> perf_cycles equals the measured start-to-done cycle count and holds after done.
